// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: the channel FSM
// encoding and the default parameter values.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_e;

   localparam int DEF_N_BTN        = 5;
   localparam int DEF_SAMPLE_DIV   = 100000;
   localparam int DEF_DEB_CYCLES   = 8;
   localparam int DEF_LONG_TICKS   = 500;
   localparam int DEF_REPEAT_TICKS = 100;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-sampled history with
// hysteresis, and the IDLE/PRESSED/HELD FSM producing one-clock pulses.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_raw,
   output logic       level,
   output logic       press_1p,
   output logic       release_1p,
   output logic       long_1p,
   output logic       repeat_1p,
   output btn_state_e state
);

   localparam int HOLD_W = $clog2(LONG_TICKS + 1);
   localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
   localparam logic [REP_W-1:0]  REP_TGT  = REP_W'(REPEAT_TICKS);

   logic [1:0]            sync_q;
   logic [DEB_CYCLES-1:0] hist, hist_n;
   logic                  level_n, rise, fall;
   btn_state_e            state_n;
   logic [HOLD_W-1:0]     hold_cnt, hold_n;
   logic [REP_W-1:0]      rep_cnt, rep_n;
   logic                  press_n, release_n, long_n, repeat_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         hist       <= '0;
         level      <= 1'b0;
         state      <= ST_IDLE;
         hold_cnt   <= '0;
         rep_cnt    <= '0;
         press_1p   <= 1'b0;
         release_1p <= 1'b0;
         long_1p    <= 1'b0;
         repeat_1p  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], btn_raw};
         hist       <= hist_n;
         level      <= level_n;
         state      <= state_n;
         hold_cnt   <= hold_n;
         rep_cnt    <= rep_n;
         press_1p   <= press_n;
         release_1p <= release_n;
         long_1p    <= long_n;
         repeat_1p  <= repeat_n;
      end
   end

   // The FSM works on the level being written this edge, so pulses and the
   // new level become visible in the same clock.
   always_comb begin
      hist_n    = hist;
      level_n   = level;
      state_n   = state;
      hold_n    = hold_cnt;
      rep_n     = rep_cnt;
      press_n   = 1'b0;
      release_n = 1'b0;
      long_n    = 1'b0;
      repeat_n  = 1'b0;

      if (tick) hist_n = {hist[DEB_CYCLES-2:0], sync_q[1]};
      if (&hist_n)       level_n = 1'b1;
      else if (~|hist_n) level_n = 1'b0;
      rise = level_n & ~level;
      fall = ~level_n & level;

      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_n = ST_PRESSED;
               press_n = 1'b1;
               hold_n  = '0;
            end
         end
         ST_PRESSED: begin
            if (fall) begin
               state_n   = ST_IDLE;
               release_n = 1'b1;
            end else if (tick) begin
               if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
               if (hold_n == HOLD_TGT) begin
                  state_n = ST_HELD;
                  long_n  = 1'b1;
                  rep_n   = '0;
               end
            end
         end
         ST_HELD: begin
            if (fall) begin
               state_n   = ST_IDLE;
               release_n = 1'b1;
            end else if (tick && (REPEAT_TICKS != 0)) begin
               rep_n = rep_cnt + 1'b1;
               if (rep_n == REP_TGT) begin
                  repeat_n = 1'b1;
                  rep_n    = '0;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: shared sample tick, one conditioning
// channel per button and a lowest-index press encoder.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN        = DEF_N_BTN,
   parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   localparam int ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_BTN-1:0]   btn_raw,
   output logic [N_BTN-1:0]   btn_level,
   output logic [N_BTN-1:0]   press_1p,
   output logic [N_BTN-1:0]   release_1p,
   output logic [N_BTN-1:0]   long_1p,
   output logic [N_BTN-1:0]   repeat_1p,
   output logic [ID_W-1:0]    press_id,
   output logic               press_valid,
   output logic [2*N_BTN-1:0] state_dbg
);

   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   // With SAMPLE_DIV=1 the counter stays at 0 and tick is high every cycle.
   assign tick = (tick_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_state_e ch_state;

      btn_channel #(
         .DEB_CYCLES  (DEB_CYCLES),
         .LONG_TICKS  (LONG_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick      (tick),
         .btn_raw   (btn_raw[i]),
         .level     (btn_level[i]),
         .press_1p  (press_1p[i]),
         .release_1p(release_1p[i]),
         .long_1p   (long_1p[i]),
         .repeat_1p (repeat_1p[i]),
         .state     (ch_state)
      );

      assign state_dbg[2*i +: 2] = ch_state;
   end

   always_comb begin
      press_id = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press_1p[i]) press_id = ID_W'(i);
      end
   end

   assign press_valid = |press_1p;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel front end for the board push-buttons. It synchronises and debounces N raw inputs on a shared sample tick, with hysteresis. Per channel it emits a stable level plus one-clock press, release, long-press and auto-repeat pulses. A priority-encoded "which button was just pressed" index feeds the game/menu FSMs directly.

## Interface
Parameters:
- N_BTN, 5: number of button channels (1–8).
- SAMPLE_DIV, 100000: clk cycles per debounce sample tick (≥1).
- DEB_CYCLES, 8: consecutive equal samples required to change level (2–16).
- LONG_TICKS, 500: sample ticks held before long_1p (≥1).
- REPEAT_TICKS, 100: sample ticks between repeat_1p pulses after long press; 0 disables repeat.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw pad inputs, asynchronous to clk.
- btn_level  out  N_BTN  debounced level, registered.
- press_1p  out  N_BTN  one-clk pulse on debounced 0→1.
- release_1p  out  N_BTN  one-clk pulse on debounced 1→0.
- long_1p  out  N_BTN  one-clk pulse when hold reaches LONG_TICKS.
- repeat_1p  out  N_BTN  one-clk pulse every REPEAT_TICKS after long press.
- press_id  out  max(1,$clog2(N_BTN))  lowest index with press_1p set, else 0.
- press_valid  out  1  |press_1p, same cycle as press_id.

## Operation
- Tick generator: counter 0..SAMPLE_DIV-1, wraps; tick=1 for one clk when count==SAMPLE_DIV-1. Shared by all channels. SAMPLE_DIV=1 gives tick every cycle.
- Per channel: 2-flop synchroniser. On tick, shift the synchronised bit into a DEB_CYCLES-bit history.
- Level hysteresis: level←1 when history is all ones, ←0 when all zeros, otherwise hold. A partial glitch never changes level.
- Per-channel FSM (encoding IDLE=0, PRESSED=1, HELD=2):
  - IDLE: level rises → PRESSED, press_1p, hold_cnt←0.
  - PRESSED: each tick hold_cnt+1. hold_cnt reaching LONG_TICKS → HELD, long_1p, rep_cnt←0. Level falls → IDLE, release_1p, no long_1p.
  - HELD: each tick rep_cnt+1. rep_cnt reaching REPEAT_TICKS (≠0) → repeat_1p, rep_cnt←0. Level falls → IDLE, release_1p.
- Level fall has priority over long/repeat in the same cycle: only release_1p fires.
- hold_cnt is sized $clog2(LONG_TICKS+1) and saturates. rep_cnt is sized $clog2(REPEAT_TICKS+1).
- press_id: lowest-index set bit of press_1p. Simultaneous presses on channels 1 and 3 give id=1, valid=1. Every channel still gets its own press_1p.
- All pulse outputs are exactly one clk wide, regardless of SAMPLE_DIV.

## Timing
- Reset (async assert, sync release via rst_n into flops): all outputs 0, including press_id and press_valid. Histories, counters and tick counter are 0; FSMs are IDLE.
- Reset mid-hold: no release_1p is generated. After release of reset, a still-pressed button produces press_1p once it is re-debounced.
- Press latency from a stable raw edge: 2 sync clks, then DEB_CYCLES ticks. Bound: ≤ 2 + DEB_CYCLES·SAMPLE_DIV + 1 clks.
- btn_level and press_1p/release_1p assert in the same clk, the first cycle the new level is visible.
- long_1p: in the clk after the LONG_TICKS-th tick following press_1p.
- repeat_1p: every REPEAT_TICKS ticks after long_1p.

## Structure
- Package btn_pkg holds the FSM state encoding constants and default parameter values.
- Sub-module btn_channel covers one channel: synchroniser, history, level, FSM, counters and four pulses. The top generates N_BTN instances, the shared tick counter and the priority encoder.

## Test plan
Unless stated, N_BTN=4, SAMPLE_DIV=4, DEB_CYCLES=4, LONG_TICKS=10, REPEAT_TICKS=3.
- Reset: rst_n=0 with btn_raw=4'hF → every output 0. Release reset → press_1p=4'hF within 19 clks, press_id=0, press_valid=1 for 1 clk.
- Bounce: btn_raw[2] toggles every 5 clks for 60 clks, then held 1 → no pulse during the toggling. Exactly one press_1p[2] appears after it settles.
- Release before long: hold btn_raw[1] for 6 ticks after press, then 0 → press_1p[1] and release_1p[1] once each, long_1p=0.
- Long + repeat: hold btn_raw[0] → long_1p at tick 10 after press, repeat_1p at ticks 13, 16, 19. Release → release_1p only, no further repeat.
- Priority: channels 3 and 1 rise on the same clk → press_1p=4'b1010, press_id=1, press_valid=1.
- REPEAT_TICKS=0, held 40 ticks → exactly one long_1p, zero repeat_1p.
